// File: rtl/reg_file_sweep_if.sv
// ----------------------------------------------------------------------------
// reg_file_sweep_if
//   Bundles the read, write and clear signals of reg_file_sweep.
//
//   master : drives rd_en/rd_addr1/rd_addr2, wr_en/wr_addr/wr_data, clear_req
//   slave  : drives rd_data1/rd_data2/rd_valid, busy, state_dbg
//
//   Handshake: there is no ready signal. A read or write request is accepted
//   at a posedge exactly when busy is low at that edge. An accepted read
//   returns data one cycle later, qualified by a one-cycle rd_valid pulse.
//   Requests presented while busy is high are dropped, not stalled.
//
//   state_dbg mirrors the clear-sweep FSM state (0 = IDLE, 1 = SWEEP).
// ----------------------------------------------------------------------------
interface reg_file_sweep_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clear_req;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_valid;
  logic              busy;
  logic              state_dbg;

  modport master (
    output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clear_req,
    input  rd_data1, rd_data2, rd_valid, busy, state_dbg
  );

  modport slave (
    input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clear_req,
    output rd_data1, rd_data2, rd_valid, busy, state_dbg
  );
endinterface

// File: rtl/reg_file_sweep.sv
// ----------------------------------------------------------------------------
// reg_file_sweep
//   DEPTH = 2**ADDR_W entry register file, one write port, two registered
//   read ports (1-cycle latency, write-to-read bypass), plus a sweep FSM that
//   zeroes one entry per cycle after clear_req.
//
//   Ports:
//     clk  : system clock, posedge
//     clr  : asynchronous active-low reset (array, outputs and FSM to zero)
//     bus  : reg_file_sweep_if.slave (read/write/clear requests, read data,
//            rd_valid, busy, state_dbg)
//
//   Build option: define REG_FILE_ZERO_REG_EN to hardwire entry 0 to zero
//   (writes to address 0 dropped, no bypass for address 0).
// ----------------------------------------------------------------------------
module reg_file_sweep #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               clr,
  reg_file_sweep_if.slave    bus
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_n;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              rd_ok;
  logic              wr_ok;
  logic              sweep_clr;
  logic [DATA_W-1:0] rd_val1;
  logic [DATA_W-1:0] rd_val2;

  assign busy = (state == SWEEP);

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sweep_clr = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.clear_req) state_n = SWEEP;
      end
      SWEEP: begin
        sweep_clr = 1'b1;
        // Counter wraps back to zero on the final entry, so it is already
        // primed for the next sweep.
        cnt_n     = cnt + ADDR_W'(1);
        if (cnt == {ADDR_W{1'b1}}) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request acceptance and bypass
  // ---------------------------------------------------------------------------
  // With the zero register enabled a write to address 0 is never accepted,
  // which also removes it from the bypass path.
  always_comb begin
    rd_ok = bus.rd_en && !busy;
    wr_ok = bus.wr_en && !busy;
    if (ZERO_REG && (bus.wr_addr == '0)) wr_ok = 1'b0;
  end

  always_comb begin
    rd_val1 = mem[bus.rd_addr1];
    rd_val2 = mem[bus.rd_addr2];
    if (wr_ok && (bus.wr_addr == bus.rd_addr1)) rd_val1 = bus.wr_data;
    if (wr_ok && (bus.wr_addr == bus.rd_addr2)) rd_val2 = bus.wr_data;
  end

  // ---------------------------------------------------------------------------
  // Storage. Sweep and write never coincide: writes are only accepted in IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (sweep_clr) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read output registers: hold on idle/busy cycles, rd_valid is a pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus.rd_data1 <= '0;
      bus.rd_data2 <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= rd_ok;
      if (rd_ok) begin
        bus.rd_data1 <= rd_val1;
        bus.rd_data2 <= rd_val2;
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_reg_file_sweep.sv
// ----------------------------------------------------------------------------
// tb_reg_file_sweep
//   Randomized and directed stimulus for reg_file_sweep (DATA_W=8, ADDR_W=4)
//   against an array-based reference model. Reads observed on rd_valid are
//   matched against an expected queue.
// ----------------------------------------------------------------------------
module tb_reg_file_sweep;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  reg_file_sweep_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file_sweep #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  // --------------------------------------------------------------------------
  // Reference model and scoreboard
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]   mem_m [DEPTH];
  int                  sweep_left;
  logic                exp_valid;
  logic [2*DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0]   last1;
  logic [DATA_W-1:0]   last2;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    sweep_left = 0;
    exp_valid  = 1'b0;
    last1      = '0;
    last2      = '0;
    exp_q.delete();
  endtask

  // One posedge of model behaviour. A same-cycle write is applied first so
  // reads see the newest data for that address.
  task automatic model_step(input logic re, input logic [ADDR_W-1:0] a1,
                            input logic [ADDR_W-1:0] a2, input logic we,
                            input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                            input logic cr);
    if (sweep_left > 0) begin
      mem_m[DEPTH - sweep_left] = '0;
      sweep_left--;
      exp_valid = 1'b0;
    end else begin
      if (we && !(ZERO_REG && wa == 0)) mem_m[wa] = wd;
      exp_valid = re;
      if (re) exp_q.push_back({mem_m[a1], mem_m[a2]});
      if (cr) sweep_left = DEPTH;
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver: called at a negedge, returns at the next negedge
  // --------------------------------------------------------------------------
  task automatic step(input logic re, input logic [ADDR_W-1:0] a1,
                      input logic [ADDR_W-1:0] a2, input logic we,
                      input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic cr);
    logic [2*DATA_W-1:0] e;
    bus.rd_en     = re;
    bus.rd_addr1  = a1;
    bus.rd_addr2  = a2;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.clear_req = cr;
    @(posedge clk);
    model_step(re, a1, a2, we, wa, wd, cr);
    #1;
    check("rd_valid", {31'b0, bus.rd_valid}, {31'b0, exp_valid});
    check("busy", {31'b0, bus.busy}, {31'b0, sweep_left > 0});
    check("state_dbg", {31'b0, bus.state_dbg}, {31'b0, sweep_left > 0});
    if (exp_valid && exp_q.size() > 0) begin
      e     = exp_q.pop_front();
      last1 = e[2*DATA_W-1:DATA_W];
      last2 = e[DATA_W-1:0];
    end
    check("rd_data1", {24'b0, bus.rd_data1}, {24'b0, last1});
    check("rd_data2", {24'b0, bus.rd_data2}, {24'b0, last2});
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic write(input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    step(1'b0, '0, '0, 1'b1, wa, wd, 1'b0);
  endtask

  task automatic read(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    step(1'b1, a1, a2, 1'b0, '0, '0, 1'b0);
  endtask

  // Asserts clr mid-cycle, checks outputs before any clock edge, releases on
  // the following negedge.
  task automatic apply_reset(input string tag);
    #1 clr = 1'b0;
    #1;
    check({tag, "_busy"},   {31'b0, bus.busy},     32'd0);
    check({tag, "_valid"},  {31'b0, bus.rd_valid}, 32'd0);
    check({tag, "_rdata1"}, {24'b0, bus.rd_data1}, 32'd0);
    check({tag, "_rdata2"}, {24'b0, bus.rd_data2}, 32'd0);
    model_reset();
    @(negedge clk);
    clr = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int busy_cnt;

  initial begin
    bus.rd_en = 1'b0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.clear_req = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset("por");
    idle();

    // Write/read pattern with crossed addresses
    for (int i = 0; i < DEPTH; i++) write(ADDR_W'(i), 8'h10 + 8'(i));
    for (int i = 0; i < DEPTH; i++) read(ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));
    read(4'd3, 4'd12);
    check("wr_rd_d1", {24'b0, bus.rd_data1}, 32'h13);
    check("wr_rd_d2", {24'b0, bus.rd_data2}, 32'h1C);
    idle();

    // Reset with array populated: everything reads zero afterwards
    apply_reset("rst_full");
    for (int i = 0; i < DEPTH; i++) read(ADDR_W'(i), ADDR_W'(i));

    // Bypass on both ports
    write(4'd5, 8'hAA);
    step(1'b1, 4'd5, 4'd5, 1'b1, 4'd5, 8'h55, 1'b0);
    check("byp_d1", {24'b0, bus.rd_data1}, 32'h55);
    check("byp_d2", {24'b0, bus.rd_data2}, 32'h55);
    read(4'd5, 4'd0);
    check("byp_after", {24'b0, bus.rd_data1}, 32'h55);

    // Sweep: busy for DEPTH cycles, writes/reads ignored throughout
    for (int i = 0; i < DEPTH; i++) write(ADDR_W'(i), 8'($urandom_range(1, 255)));
    busy_cnt = 0;
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    busy_cnt += int'(bus.busy);
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b1, ADDR_W'($urandom_range(0, 15)), ADDR_W'($urandom_range(0, 15)),
           1'b1, ADDR_W'($urandom_range(0, 15)), 8'hFF, 1'b0);
      busy_cnt += int'(bus.busy);
    end
    check("busy_len", busy_cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) read(ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));

    // Level clear_req held past the end of a sweep restarts it
    for (int i = 0; i < DEPTH + 3; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) idle();

    // Abort: reset on the 7th busy cycle
    for (int i = 0; i < DEPTH; i++) write(ADDR_W'(i), 8'h80 + 8'(i));
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 6; i++) idle();
    check("abort_busy_pre", {31'b0, bus.busy}, 32'd1);
    apply_reset("abort");
    write(4'd3, 8'h3C);
    read(4'd3, 4'd9);
    check("abort_wr", {24'b0, bus.rd_data1}, 32'h3C);
    for (int i = 0; i < DEPTH; i++) read(ADDR_W'(i), ADDR_W'(i));

    // Address 0 with same-cycle write and read
    step(1'b1, 4'd0, 4'd1, 1'b1, 4'd0, 8'h77, 1'b0);
    check("a0_byp", {24'b0, bus.rd_data1}, ZERO_REG ? 32'h00 : 32'h77);
    read(4'd0, 4'd0);
    check("a0_later", {24'b0, bus.rd_data1}, ZERO_REG ? 32'h00 : 32'h77);
    step(1'b1, 4'd1, 4'd1, 1'b1, 4'd1, 8'h66, 1'b0);
    check("a1_byp", {24'b0, bus.rd_data1}, 32'h66);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)),
           ADDR_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ADDR_W'($urandom_range(0, 15)), 8'($urandom),
           $urandom_range(0, 39) == 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) idle();
    for (int i = 0; i < DEPTH; i++) read(ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_sweep.md
Name: reg_file_sweep

Overview:
- Parametrised register file; successor to the fixed 16x8 bank.
- One write port and two read ports; reads are registered with 1-cycle latency and write-to-read bypass.
- A clear-sweep state machine zeroes the array one entry per cycle on command.
- Sits in the datapath between instruction decode (read addresses) and writeback (write port).

Parameters:
- DATA_W, 8, width of each register in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.

Ports:
- clk  input  1  system clock; all sequential logic on posedge.
- clr  input  1  asynchronous active-low reset.
- rd_en  input  1  read request for both read ports.
- rd_addr1  input  ADDR_W  read port 1 address.
- rd_addr2  input  ADDR_W  read port 2 address.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- clear_req  input  1  start a sweep clear of all entries (single-cycle pulse or level).
- rd_data1  output  DATA_W  registered read data, port 1.
- rd_data2  output  DATA_W  registered read data, port 2.
- rd_valid  output  1  rd_data1/rd_data2 updated this cycle.
- busy  output  1  sweep in progress; read and write requests are ignored.

Behaviour:
- Reset (clr=0, asynchronous, takes effect without a clock edge):
  - all DEPTH entries = 0; rd_data1 = rd_data2 = 0; rd_valid = 0; busy = 0.
  - FSM = IDLE; sweep counter = 0.
  - Normal operation resumes on the first posedge after clr rises.
- Write: at posedge, if wr_en=1 and busy=0, entry[wr_addr] <= wr_data. With wr_en=0 or busy=1, no array change.
- Read: at posedge, if rd_en=1 and busy=0:
  - rd_dataN <= bypassed value of entry[rd_addrN]; rd_valid <= 1.
  - Latency: 1 cycle from address to data.
- No read (rd_en=0 or busy=1): rd_valid <= 0; rd_data1 and rd_data2 hold their last values.
- Bypass: if the same cycle also accepts a write with wr_addr == rd_addrN, rd_dataN <= wr_data (new data), not the stale entry. Applies independently per port.
- Both read ports may use the same address; both return identical data.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP at a posedge where clear_req=1. busy <= 1; counter <= 0.
  - Any read or write accepted in that same cycle completes normally; the sweep later overwrites written data.
  - SWEEP: each posedge, entry[counter] <= 0 and counter <= counter+1.
  - When counter == DEPTH-1: clear the last entry, go to IDLE, busy <= 0.
  - busy is high for exactly DEPTH cycles.
  - Counter is ADDR_W bits wide; it wraps to 0 on exit, with no overflow state.
- clear_req while busy=1 is ignored and does not restart or extend the sweep.
- A clear_req level still high on the cycle busy falls starts a new sweep.
- rd_data outputs are not zeroed by a sweep; they hold until the next accepted read.
- Reset asserted mid-sweep: immediate return to IDLE; all entries zero; busy = 0.

Optional Feature:
- Macro: REG_FILE_ZERO_REG_EN.
- Defined: entry 0 is hardwired zero.
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0, including when a write to address 0 is issued in the same cycle (no bypass for address 0).
  - The sweep still takes DEPTH cycles.
- Undefined: entry 0 is an ordinary register.

Test Plan (DATA_W=8, ADDR_W=4):
- Reset check: clr low with the array previously written -> all 16 entries read 0x00; rd_valid=0; busy=0 immediately, without a clock edge.
- Write/read: write 0x10+i to entry i for i=0..15. Then rd_en with rd_addr1=i, rd_addr2=15-i -> one cycle later rd_data1=0x10+i, rd_data2=0x1F-i, rd_valid=1.
- Bypass: entry 5 = 0xAA; same cycle wr_en addr 5 data 0x55 and rd_en rd_addr1=5, rd_addr2=5 -> next cycle both outputs 0x55. A following read of entry 5 -> 0x55.
- Sweep: fill the array, pulse clear_req -> busy high exactly 16 cycles. Writes of 0xFF issued during busy are ignored; rd_valid stays 0 throughout. Afterwards all entries read 0x00.
- Sweep abort: reset asserted on the 7th busy cycle -> busy=0 immediately; all entries 0; a write after clr rises is accepted.
- REG_FILE_ZERO_REG_EN build: write 0x77 to address 0 with a simultaneous read of address 0 -> rd_data1=0x00 on both that read and a later one; address 1 behaves normally.
